rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: W-stage writes win, MD-unit writes queue in a 2-deep FIFO, aged head is forced.
// Latency: grant is combinational in the cycle the write is presented; a queued MD write drains no earlier than the cycle after its push.
// Backpressure: md_ready drops while the FIFO is full; wb_stall holds the pipeline for the single cycle a starved MD write is forced.
//
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   wb_req/wb_addr/wb_data/wb_pc    primary write from the pipeline W-stage
//   md_valid/md_ready/md_addr/...   secondary write offer from the multiply/divide unit
//   q1_addr/q1_hit, q2_addr/q2_hit  hazard queries against queued MD writes
//   wb_stall                        pipeline must not present wb_req
//   RFWrEn/A3/WD/PC                 single register-file write port (zeroed when idle)
module rf_wb_arbiter #(
  parameter int AGE_LIMIT = 4  // 2..15: blocked cycles tolerated before the head is forced
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_req,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        md_valid,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  input  logic [31:0] md_pc,
  output logic        md_ready,
  input  logic [4:0]  q1_addr,
  input  logic [4:0]  q2_addr,
  output logic        q1_hit,
  output logic        q2_hit,
  output logic        wb_stall,
  output logic        RFWrEn,
  output logic [4:0]  A3,
  output logic [31:0] WD,
  output logic [31:0] PC
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } md_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

  localparam logic [3:0] AGE_FORCE = 4'(AGE_LIMIT - 1);

  state_t    state;
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [3:0] age;
  logic       stall_q;
  md_entry_t  mem [2];

  md_entry_t  head;
  logic       push;
  logic       pop;
  logic       grant_wb;
  logic       grant_head;
  logic [1:0] count_next;
  logic [3:0] age_next;
  logic       vld0;
  logic       vld1;

  assign head     = mem[rd_ptr];
  // Readiness is judged on the pre-pop count: a full FIFO never accepts, even while draining.
  assign md_ready = reset && (count != 2'd2);
  // $0 offers are handshaken so the MD unit is not held, but never stored.
  assign push     = md_ready && md_valid && (md_addr != 5'd0);
  assign pop      = grant_head;
  assign wb_stall = reset && stall_q;

  always_comb begin
    grant_wb   = 1'b0;
    grant_head = 1'b0;
    if (reset) begin
      if (state == S_FORCE) begin
        // Any wb_req here violates the stall and is dropped.
        grant_head = (count != 2'd0);
      end else if (wb_req && (wb_addr != 5'd0)) begin
        grant_wb = 1'b1;
      end else if (count != 2'd0) begin
        grant_head = 1'b1;
      end
    end
  end

  always_comb begin
    RFWrEn = 1'b0;
    A3     = 5'd0;
    WD     = 32'd0;
    PC     = 32'd0;
    if (grant_wb) begin
      RFWrEn = 1'b1;
      A3     = wb_addr;
      WD     = wb_data;
      PC     = wb_pc;
    end else if (grant_head) begin
      RFWrEn = 1'b1;
      A3     = head.addr;
      WD     = head.data;
      PC     = head.pc;
    end
  end

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (!push && pop) begin
      count_next = count - 2'd1;
    end
  end

  // Age counts consecutive cycles the current head is passed over; a fresh head starts at zero.
  always_comb begin
    age_next = age;
    if (pop || (count_next == 2'd0)) begin
      age_next = 4'd0;
    end else if ((count != 2'd0) && !grant_head) begin
      age_next = age + 4'd1;
    end
  end

  // Entry i is live when the FIFO is full, or when it is the head of a single-entry FIFO.
  assign vld0 = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'b0));
  assign vld1 = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'b1));

  assign q1_hit = reset && (q1_addr != 5'd0) &&
                  ((vld0 && (mem[0].addr == q1_addr)) || (vld1 && (mem[1].addr == q1_addr)));
  assign q2_hit = reset && (q2_addr != 5'd0) &&
                  ((vld0 && (mem[0].addr == q2_addr)) || (vld1 && (mem[1].addr == q2_addr)));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: md_addr, data: md_data, pc: md_pc};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      age     <= 4'd0;
      stall_q <= 1'b0;
    end else begin
      count <= count_next;
      age   <= age_next;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case (state)
        S_IDLE: begin
          if (count_next != 2'd0) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (count_next == 2'd0) begin
            state <= S_IDLE;
          end else if (!pop && (age_next == AGE_FORCE)) begin
            state   <= S_FORCE;
            stall_q <= 1'b1;
          end
        end
        S_FORCE: begin
          stall_q <= 1'b0;
          state   <= (count_next != 2'd0) ? S_WAIT : S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed cycle vectors with hand-written expectations,
// followed by randomized traffic compared against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int AGE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_req = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic [31:0] wb_pc = 32'd0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_addr = 5'd0;
  logic [31:0] md_data = 32'd0;
  logic [31:0] md_pc = 32'd0;
  logic        md_ready;
  logic [4:0]  q1_addr = 5'd0;
  logic [4:0]  q2_addr = 5'd0;
  logic        q1_hit;
  logic        q2_hit;
  logic        wb_stall;
  logic        RFWrEn;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [31:0] PC;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.AGE_LIMIT(AGE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_pc(md_pc),
    .md_ready(md_ready),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_hit(q1_hit), .q2_hit(q2_hit),
    .wb_stall(wb_stall),
    .RFWrEn(RFWrEn), .A3(A3), .WD(WD), .PC(PC)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        wb_req;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_ready;
    logic        e_stall;
    logic        e_wren;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_q1;
    logic        e_q2;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  // Reference model: pending MD writes in arrival order, plus how long the head has been passed over.
  ent_t mq[$];
  int   blocked = 0;
  bit   forced = 1'b0;

  function automatic logic [31:0] pc_of(input logic [31:0] d);
    return {d[15:0], d[31:16]} ^ 32'h0F0F_0F0F;
  endfunction

  function automatic vec_t mk(input bit [31:0] rst, wbr, wba, wbd, mdv, mda, mdd, q1, q2,
                              er, es, ew, ea3, ewd, eq1, eq2);
    vec_t v;
    v.rst = rst[0];     v.wb_req = wbr[0];   v.wb_addr = wba[4:0]; v.wb_data = wbd;
    v.md_valid = mdv[0]; v.md_addr = mda[4:0]; v.md_data = mdd;
    v.q1 = q1[4:0];     v.q2 = q2[4:0];
    v.e_ready = er[0];  v.e_stall = es[0];   v.e_wren = ew[0];    v.e_a3 = ea3[4:0];
    v.e_wd = ewd;       v.e_q1 = eq1[0];     v.e_q2 = eq2[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic er, input logic es, input logic ew,
                           input logic [4:0] ea3, input logic [31:0] ewd, input logic [31:0] epc,
                           input logic eq1, input logic eq2);
    chk($sformatf("%s.md_ready", tag), 32'(md_ready), 32'(er));
    chk($sformatf("%s.wb_stall", tag), 32'(wb_stall), 32'(es));
    chk($sformatf("%s.RFWrEn", tag),   32'(RFWrEn),   32'(ew));
    chk($sformatf("%s.A3", tag),       32'(A3),       32'(ea3));
    chk($sformatf("%s.WD", tag),       WD,            ewd);
    chk($sformatf("%s.PC", tag),       PC,            epc);
    chk($sformatf("%s.q1_hit", tag),   32'(q1_hit),   32'(eq1));
    chk($sformatf("%s.q2_hit", tag),   32'(q2_hit),   32'(eq2));
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    reset    = v.rst;
    wb_req   = v.wb_req;
    wb_addr  = v.wb_addr;
    wb_data  = v.wb_data;
    wb_pc    = pc_of(v.wb_data);
    md_valid = v.md_valid;
    md_addr  = v.md_addr;
    md_data  = v.md_data;
    md_pc    = pc_of(v.md_data);
    q1_addr  = v.q1;
    q2_addr  = v.q2;
    #1;
    if (v.rst && v.wb_req && wb_stall)
      $display("note: protocol error, wb_req presented during stall (%s)", tag);
    check_out(tag, v.e_ready, v.e_stall, v.e_wren, v.e_a3, v.e_wd,
              v.e_wren ? pc_of(v.e_wd) : 32'd0, v.e_q1, v.e_q2);
  endtask

  task automatic rand_cycle(input int idx);
    logic        r;
    logic        take_head;
    logic        take_wb;
    logic        had_head;
    logic        e_ready;
    logic        e_wren;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic [31:0] e_pc;
    logic        e_q1;
    logic        e_q2;
    ent_t        e;

    @(negedge clk);
    r = (idx == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
    reset    = r;
    wb_req   = forced ? 1'b0 : 1'($urandom_range(0, 1));
    wb_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    wb_data  = $urandom;
    wb_pc    = $urandom;
    md_valid = 1'($urandom_range(0, 1));
    md_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    md_data  = $urandom;
    md_pc    = $urandom;
    q1_addr  = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[$urandom_range(0, mq.size() - 1)].addr
                                                            : 5'($urandom_range(0, 31));
    q2_addr  = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[$urandom_range(0, mq.size() - 1)].addr
                                                            : 5'($urandom_range(0, 31));
    #1;

    e_ready   = r && (mq.size() < 2);
    take_head = 1'b0;
    take_wb   = 1'b0;
    if (r) begin
      if (forced) take_head = 1'b1;
      else if (wb_req && wb_addr != 5'd0) take_wb = 1'b1;
      else if (mq.size() > 0) take_head = 1'b1;
    end
    e_wren = take_head || take_wb;
    e_a3 = 5'd0; e_wd = 32'd0; e_pc = 32'd0;
    if (take_wb) begin
      e_a3 = wb_addr; e_wd = wb_data; e_pc = wb_pc;
    end else if (take_head) begin
      e_a3 = mq[0].addr; e_wd = mq[0].data; e_pc = mq[0].pc;
    end
    e_q1 = 1'b0;
    e_q2 = 1'b0;
    if (r) begin
      foreach (mq[k]) begin
        if (q1_addr != 5'd0 && mq[k].addr == q1_addr) e_q1 = 1'b1;
        if (q2_addr != 5'd0 && mq[k].addr == q2_addr) e_q2 = 1'b1;
      end
    end
    check_out($sformatf("rnd%0d", idx), e_ready, r && forced, e_wren, e_a3, e_wd, e_pc, e_q1, e_q2);

    if (!r) begin
      mq.delete();
      blocked = 0;
      forced  = 1'b0;
    end else begin
      had_head = (mq.size() > 0);
      if (take_head) void'(mq.pop_front());
      if (e_ready && md_valid && md_addr != 5'd0) begin
        e.addr = md_addr; e.data = md_data; e.pc = md_pc;
        mq.push_back(e);
      end
      if (take_head || mq.size() == 0) begin
        blocked = 0;
        forced  = 1'b0;
      end else if (had_head) begin
        blocked++;
        forced = (blocked == AGE_LIMIT - 1);
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    // rst wbr wba wbd          mdv mda mdd            q1  q2   rdy stl wen a3  wd             h1 h2
    tbl.push_back(mk(0, 1, 3, 'h1111_1111, 1, 5, 'h2222_2222, 5, 5,   0, 0, 0, 0, 0,             0, 0));
    tbl.push_back(mk(0, 0, 0, 0,           0, 0, 0,           0, 0,   0, 0, 0, 0, 0,             0, 0));
    tbl.push_back(mk(1, 0, 0, 0,           1, 5, 'h1234_5678, 5, 0,   1, 0, 0, 0, 0,             0, 0));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,           5, 6,   1, 0, 1, 5, 'h1234_5678,   1, 0));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,           5, 6,   1, 0, 0, 0, 0,             0, 0));
    tbl.push_back(mk(1, 1, 3, 'h33,        1, 7, 'h77,        7, 0,   1, 0, 1, 3, 'h33,          0, 0));
    tbl.push_back(mk(1, 1, 3, 'h34,        0, 0, 0,           7, 3,   1, 0, 1, 3, 'h34,          1, 0));
    tbl.push_back(mk(1, 1, 3, 'h35,        0, 0, 0,           7, 0,   1, 0, 1, 3, 'h35,          1, 0));
    tbl.push_back(mk(1, 1, 3, 'h36,        0, 0, 0,           7, 0,   1, 0, 1, 3, 'h36,          1, 0));
    tbl.push_back(mk(1, 1, 3, 'h37,        0, 0, 0,           7, 0,   1, 1, 1, 7, 'h77,          1, 0));
    tbl.push_back(mk(1, 1, 3, 'h38,        0, 0, 0,           7, 0,   1, 0, 1, 3, 'h38,          0, 0));
    tbl.push_back(mk(1, 1, 3, 'h39,        1, 9, 'h99,        9, 0,   1, 0, 1, 3, 'h39,          0, 0));
    tbl.push_back(mk(1, 1, 0, 'hDEAD,      1, 0, 'hBEEF,      0, 9,   1, 0, 1, 9, 'h99,          0, 1));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,           0, 9,   1, 0, 0, 0, 0,             0, 0));
    tbl.push_back(mk(1, 1, 3, 'h3A,        1, 12, 'hC,        12, 13, 1, 0, 1, 3, 'h3A,          0, 0));
    tbl.push_back(mk(1, 1, 3, 'h3B,        0, 0, 0,           12, 13, 1, 0, 1, 3, 'h3B,          1, 0));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,           12, 13, 1, 0, 1, 12, 'hC,          1, 0));
    tbl.push_back(mk(1, 0, 0, 0,           0, 0, 0,           12, 13, 1, 0, 0, 0, 0,             0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // FIFO full while the primary keeps the port busy; third offer waits, drain order A, B, C.
    apply_vec(mk(1, 1, 3, 'h40, 1, 10, 'hA0, 0, 0,   1, 0, 1, 3, 'h40,  0, 0), "full0");
    apply_vec(mk(1, 1, 3, 'h41, 1, 11, 'hB0, 10, 11, 1, 0, 1, 3, 'h41,  1, 0), "full1");
    apply_vec(mk(1, 1, 3, 'h42, 1, 12, 'hC0, 10, 11, 0, 0, 1, 3, 'h42,  1, 1), "full2");
    apply_vec(mk(1, 1, 3, 'h43, 1, 12, 'hC0, 12, 11, 0, 0, 1, 3, 'h43,  0, 1), "full3");
    apply_vec(mk(1, 0, 0, 0,    1, 12, 'hC0, 10, 11, 0, 1, 1, 10, 'hA0, 1, 1), "full4");
    apply_vec(mk(1, 1, 3, 'h44, 1, 12, 'hC0, 10, 11, 1, 0, 1, 3, 'h44,  0, 1), "full5");
    apply_vec(mk(1, 0, 0, 0,    0, 0, 0,     11, 12, 0, 0, 1, 11, 'hB0, 1, 1), "full6");
    apply_vec(mk(1, 0, 0, 0,    0, 0, 0,     11, 12, 1, 0, 1, 12, 'hC0, 0, 1), "full7");
    apply_vec(mk(1, 0, 0, 0,    0, 0, 0,     11, 12, 1, 0, 0, 0, 0,     0, 0), "full8");

    // Reset lands on the forced-grant cycle: nothing written, queue discarded.
    apply_vec(mk(1, 1, 3, 'h50, 1, 20, 'hD0, 20, 0,  1, 0, 1, 3, 'h50,  0, 0), "rstf0");
    apply_vec(mk(1, 1, 3, 'h51, 0, 0, 0,     20, 0,  1, 0, 1, 3, 'h51,  1, 0), "rstf1");
    apply_vec(mk(1, 1, 3, 'h52, 0, 0, 0,     20, 0,  1, 0, 1, 3, 'h52,  1, 0), "rstf2");
    apply_vec(mk(1, 1, 3, 'h53, 0, 0, 0,     20, 0,  1, 0, 1, 3, 'h53,  1, 0), "rstf3");
    apply_vec(mk(0, 1, 3, 'h55, 1, 21, 'hE0, 20, 0,  0, 0, 0, 0, 0,     0, 0), "rstf4");
    apply_vec(mk(1, 0, 0, 0,    0, 0, 0,     20, 21, 1, 0, 0, 0, 0,     0, 0), "rstf5");
    apply_vec(mk(1, 1, 3, 'h54, 0, 0, 0,     20, 0,  1, 0, 1, 3, 'h54,  0, 0), "rstf6");

    for (int i = 0; i < 3000; i++) begin
      rand_cycle(i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
